jtag_scan_sequencer: RTL and testbench
======================================

JTAG_SCAN_SEQUENCER -- requirements
Module: jtag_scan_sequencer

Interface
REQ-001 SHALL have parameter CLK_DIV, default 2, giving the TCK half-period in clk cycles (legal range 1..255).
REQ-002 SHALL have port clk, input, 1, the single system clock; all logic is on its rising edge.
REQ-003 SHALL have port rst, input, 1, the reset: synchronous and active-high.
REQ-004 SHALL have cmd_valid/cmd_ready, input/output, 1 each, the command handshake.
REQ-005 SHALL have cmd_op, input, 2: 0=RESET, 1=IR_SCAN, 2=DR_SCAN, 3=IDLE.
REQ-006 SHALL have cmd_len, input, 6: scan bit count (legal 1..32) or IDLE TCK count (0..63).
REQ-007 SHALL have cmd_data, input, 32: TDI bits, shifted LSB first.
REQ-008 SHALL have rsp_valid/rsp_ready, output/input, 1 each, the response handshake.
REQ-009 SHALL have rsp_data, output, 32: captured TDO bits.
REQ-010 SHALL have jtag_tck, jtag_tms, jtag_tdi, output, 1 each, and jtag_tdo, input, 1, the target TAP pins.
REQ-011 SHALL have busy, output, 1, high from command accept until the response is posted.
REQ-012 SHALL have tap_state, output, 4: the tracked target TAP state, encoded 0x0 TLR, 0x1 RTI, 0x2 SEL_DR ... 0xF UPD_IR (1149.1 order).

Function
REQ-013 SHALL assert cmd_ready = !busy && !rsp_valid; a command is accepted on a clk edge where cmd_valid && cmd_ready.
REQ-014 SHALL generate each TCK pulse as jtag_tck low for CLK_DIV clks, then high for CLK_DIV clks, and SHALL leave jtag_tck low when not busy.
REQ-015 SHALL change jtag_tms/jtag_tdi only on the clk edge that drives jtag_tck low, and SHALL sample jtag_tdo on the clk edge that drives jtag_tck high.
REQ-016 SHALL advance tap_state on every TCK rising edge using the 1149.1 16-state transition table with the current jtag_tms.
REQ-017 RESET SHALL issue TMS 1,1,1,1,1,0 (6 TCKs) and end with tap_state=RTI, from any starting state.
REQ-018 IR_SCAN from RTI SHALL issue TMS 1,1,0,0, then len shift TCKs (TMS=0, except TMS=1 on the last bit), then TMS 1,0; total len+6 TCKs, ending in RTI.
REQ-019 DR_SCAN from RTI SHALL issue TMS 1,0,0, then len shift TCKs (last bit TMS=1), then TMS 1,0; total len+5 TCKs, ending in RTI.
REQ-020 A scan SHALL drive jtag_tdi = cmd_data[i] during shift bit i, and SHALL drive jtag_tdi=0 outside shift bits.
REQ-021 If tap_state==TLR when a scan or IDLE command is accepted, the block SHALL prepend one TCK with TMS=0 to reach RTI.
REQ-022 IDLE SHALL issue len TCKs with TMS=0, TDI=0.
REQ-023 SHALL store the TDO sampled at shift bit i in rsp_data[i], and SHALL zero rsp_data[31:len].
REQ-024 RESET and IDLE SHALL return rsp_data=0.
REQ-025 SHALL set rsp_valid on the clk after the final TCK high phase ends (jtag_tck returned low), and hold it and rsp_data stable until rsp_ready is sampled high.
REQ-026 A scan with cmd_len=0 or cmd_len>32 SHALL generate no TCKs and SHALL return rsp_data=0 on the clk after acceptance; IDLE with len=0 behaves the same.
REQ-027 SHALL hold rsp_valid high until rsp_ready; while rsp_valid is high, cmd_ready=0, so commands never overlap or drop responses.
REQ-028 busy SHALL deassert on the same edge rsp_valid asserts.

Reset
REQ-029 On rst the block SHALL set jtag_tck=0, jtag_tms=1, jtag_tdi=0, rsp_valid=0, rsp_data=0, busy=0, cmd_ready=0 during rst and 1 on the first clk after, and tap_state=TLR.
REQ-030 rst asserted mid-command SHALL abort it without a response, and SHALL take effect on the next clk edge regardless of TCK phase.
REQ-031 After rst the target is not driven into TLR; software SHALL issue RESET before relying on target state (tap_state reflects tracking only).

Verification
REQ-032 After rst, RESET -> exactly 6 TCK pulses with TMS 1,1,1,1,1,0; tap_state=0x1; rsp_data=0.
REQ-033 CLK_DIV=2, DR_SCAN len=8 data=0xA5, 8-bit loopback TAP model (TDO = previous bypass/DR contents 0x3C) -> 13 TCKs, each phase 2 clks, rsp_data=0x0000003C, TDI sequence 1,0,1,0,0,1,0,1.
REQ-034 IR_SCAN len=4 data=0xE immediately after rst (tap_state=TLR) -> 11 TCKs (1 prepended); target model reaches SHIFT_IR, then UPDATE_IR, then RTI; tracked tap_state matches the model on every TCK.
REQ-035 DR_SCAN len=32 data=0xFFFFFFFF with rsp_ready held low 10 clks -> rsp_valid stays high and rsp_data stays stable; cmd_ready=0 until rsp_ready.
REQ-036 DR_SCAN len=0 -> no TCK activity, rsp_valid 1 clk after accept, rsp_data=0; IDLE len=5 -> 5 TCKs with TMS=0.
REQ-037 rst pulsed during shift bit 10 of a 32-bit DR_SCAN -> next clk jtag_tck=0, rsp_valid=0, busy=0, tap_state=0x0; no response is ever emitted.

Source files
------------

// File: rtl/jtag_scan_sequencer_if.sv
// jtag_scan_sequencer_if
//   Command/response handshake bundle between a host and the JTAG scan
//   sequencer.
//   cmd_valid/cmd_ready : command handshake (host -> sequencer)
//   cmd_op              : 0=RESET, 1=IR_SCAN, 2=DR_SCAN, 3=IDLE
//   cmd_len             : scan bit count (1..32) or IDLE TCK count (0..63)
//   cmd_data            : TDI bits, shifted LSB first
//   rsp_valid/rsp_ready : response handshake (sequencer -> host)
//   rsp_data            : captured TDO bits
//   modport master is the host side, modport slave is the sequencer side.
interface jtag_scan_sequencer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [5:0]  cmd_len;
  logic [31:0] cmd_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;

  modport master (
    output cmd_valid, cmd_op, cmd_len, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_len, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/jtag_scan_sequencer.sv
// jtag_scan_sequencer
//   Turns RESET / IR_SCAN / DR_SCAN / IDLE commands into TCK/TMS/TDI pin
//   activity toward a 1149.1 TAP, captures TDO during shift bits and returns
//   it as a response. Tracks the target TAP state from the TMS it issues.
//   Ports:
//     clk        : system clock, all logic on its rising edge
//     rst        : synchronous active-high reset
//     bus        : command/response handshake (jtag_scan_sequencer_if.slave)
//     jtag_tck/jtag_tms/jtag_tdi : TAP outputs
//     jtag_tdo   : TAP data input
//     busy       : high from command accept until the response is posted
//     tap_state  : tracked TAP state (1149.1 order, 0x0 TLR .. 0xF UPD_IR)
//   Parameter CLK_DIV : TCK half-period in clk cycles (1..255).
module jtag_scan_sequencer #(
  parameter int CLK_DIV = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  jtag_scan_sequencer_if.slave   bus,
  output logic                   jtag_tck,
  output logic                   jtag_tms,
  output logic                   jtag_tdi,
  input  logic                   jtag_tdo,
  output logic                   busy,
  output logic [3:0]             tap_state
);

  localparam logic [1:0] OP_RESET = 2'd0;
  localparam logic [1:0] OP_IR    = 2'd1;
  localparam logic [1:0] OP_DR    = 2'd2;

  localparam logic [3:0] TAP_TLR    = 4'h0;
  localparam logic [3:0] TAP_RTI    = 4'h1;
  localparam logic [3:0] TAP_SEL_DR = 4'h2;
  localparam logic [3:0] TAP_CAP_DR = 4'h3;
  localparam logic [3:0] TAP_SH_DR  = 4'h4;
  localparam logic [3:0] TAP_EX1_DR = 4'h5;
  localparam logic [3:0] TAP_PA_DR  = 4'h6;
  localparam logic [3:0] TAP_EX2_DR = 4'h7;
  localparam logic [3:0] TAP_UPD_DR = 4'h8;
  localparam logic [3:0] TAP_SEL_IR = 4'h9;
  localparam logic [3:0] TAP_CAP_IR = 4'hA;
  localparam logic [3:0] TAP_SH_IR  = 4'hB;
  localparam logic [3:0] TAP_EX1_IR = 4'hC;
  localparam logic [3:0] TAP_PA_IR  = 4'hD;
  localparam logic [3:0] TAP_EX2_IR = 4'hE;
  localparam logic [3:0] TAP_UPD_IR = 4'hF;

  localparam logic [7:0] DIV_M1 = 8'(CLK_DIV - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_LOW, ST_HIGH} state_t;

  function automatic logic [3:0] tap_next(input logic [3:0] s, input logic tms);
    logic [3:0] n;
    case (s)
      TAP_TLR:    n = tms ? TAP_TLR    : TAP_RTI;
      TAP_RTI:    n = tms ? TAP_SEL_DR : TAP_RTI;
      TAP_SEL_DR: n = tms ? TAP_SEL_IR : TAP_CAP_DR;
      TAP_CAP_DR: n = tms ? TAP_EX1_DR : TAP_SH_DR;
      TAP_SH_DR:  n = tms ? TAP_EX1_DR : TAP_SH_DR;
      TAP_EX1_DR: n = tms ? TAP_UPD_DR : TAP_PA_DR;
      TAP_PA_DR:  n = tms ? TAP_EX2_DR : TAP_PA_DR;
      TAP_EX2_DR: n = tms ? TAP_UPD_DR : TAP_SH_DR;
      TAP_UPD_DR: n = tms ? TAP_SEL_DR : TAP_RTI;
      TAP_SEL_IR: n = tms ? TAP_TLR    : TAP_CAP_IR;
      TAP_CAP_IR: n = tms ? TAP_EX1_IR : TAP_SH_IR;
      TAP_SH_IR:  n = tms ? TAP_EX1_IR : TAP_SH_IR;
      TAP_EX1_IR: n = tms ? TAP_UPD_IR : TAP_PA_IR;
      TAP_PA_IR:  n = tms ? TAP_EX2_IR : TAP_PA_IR;
      TAP_EX2_IR: n = tms ? TAP_UPD_IR : TAP_SH_IR;
      default:    n = tms ? TAP_SEL_DR : TAP_RTI;
    endcase
    return n;
  endfunction

  state_t      state_q;
  logic [1:0]  op_q;
  logic [5:0]  len_q;
  logic [31:0] data_q;
  logic        pre_q;
  logic [6:0]  total_q;
  logic [6:0]  k_q;
  logic [7:0]  cnt_q;
  logic        tck_q, tms_q, tdi_q, shift_q;
  logic [4:0]  bit_q;
  logic        busy_q, rsp_valid_q;
  logic [31:0] rsp_data_q;
  logic [3:0]  tap_q;

  logic        accept;
  logic        pre_d, scan_ok;
  logic [6:0]  len7, pre7, total_d;
  logic [6:0]  k_nxt, j, hdr, lenq7, idx;
  logic        tms_d, tdi_d, shift_d;
  logic [4:0]  bit_d;

  assign bus.cmd_ready = !rst && !busy_q && !rsp_valid_q;
  assign accept        = bus.cmd_valid && bus.cmd_ready;

  // Length of the TCK sequence for the command on the bus. A zero total
  // means the command completes without any pin activity.
  always_comb begin
    len7    = {1'b0, bus.cmd_len};
    pre_d   = (tap_q == TAP_TLR) && (bus.cmd_op != OP_RESET);
    pre7    = {6'd0, pre_d};
    scan_ok = (bus.cmd_len != 6'd0) && (bus.cmd_len <= 6'd32);
    total_d = '0;
    case (bus.cmd_op)
      OP_RESET: total_d = 7'd6;
      OP_IR:    if (scan_ok) total_d = len7 + 7'd6 + pre7;
      OP_DR:    if (scan_ok) total_d = len7 + 7'd5 + pre7;
      default:  if (bus.cmd_len != 6'd0) total_d = len7 + pre7;
    endcase
  end

  // TMS/TDI plan for TCK number k_nxt. The optional prepended TLR->RTI TCK
  // occupies slot 0; j is the position within the nominal sequence.
  always_comb begin
    k_nxt   = (state_q == ST_SETUP) ? 7'd0 : k_q + 7'd1;
    j       = k_nxt - {6'd0, pre_q};
    hdr     = (op_q == OP_IR) ? 7'd4 : 7'd3;
    lenq7   = {1'b0, len_q};
    idx     = j - hdr;
    tms_d   = 1'b0;
    tdi_d   = 1'b0;
    shift_d = 1'b0;
    bit_d   = '0;
    case (op_q)
      OP_RESET: tms_d = (k_nxt < 7'd5);
      OP_IR, OP_DR: begin
        if (!(pre_q && (k_nxt == 7'd0))) begin
          if (j < hdr) begin
            tms_d = (op_q == OP_IR) ? (j < 7'd2) : (j == 7'd0);
          end else if (j < hdr + lenq7) begin
            shift_d = 1'b1;
            bit_d   = idx[4:0];
            tdi_d   = data_q[idx[4:0]];
            tms_d   = (idx == lenq7 - 7'd1);
          end else begin
            tms_d = (j == hdr + lenq7);
          end
        end
      end
      default: tms_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (accept) data_q <= bus.cmd_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_RESET;
      len_q       <= '0;
      pre_q       <= 1'b0;
      total_q     <= '0;
      k_q         <= '0;
      cnt_q       <= '0;
      tck_q       <= 1'b0;
      tms_q       <= 1'b1;
      tdi_q       <= 1'b0;
      shift_q     <= 1'b0;
      bit_q       <= '0;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      tap_q       <= TAP_TLR;
    end else begin
      if (rsp_valid_q && bus.rsp_ready) rsp_valid_q <= 1'b0;
      case (state_q)
        // accept: latch the command and clear the previous response
        ST_IDLE: begin
          if (accept) begin
            op_q       <= bus.cmd_op;
            len_q      <= bus.cmd_len;
            pre_q      <= pre_d;
            total_q    <= total_d;
            busy_q     <= 1'b1;
            rsp_data_q <= '0;
            state_q    <= ST_SETUP;
          end
        end
        // setup: present the first TCK's TMS/TDI, or finish at once
        ST_SETUP: begin
          if (total_q == 7'd0) begin
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b1;
            state_q     <= ST_IDLE;
          end else begin
            k_q     <= '0;
            tck_q   <= 1'b0;
            tms_q   <= tms_d;
            tdi_q   <= tdi_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
            cnt_q   <= DIV_M1;
            state_q <= ST_LOW;
          end
        end
        // low phase: the edge that raises TCK samples TDO and steps the TAP
        ST_LOW: begin
          if (cnt_q == 8'd0) begin
            tck_q   <= 1'b1;
            cnt_q   <= DIV_M1;
            tap_q   <= tap_next(tap_q, tms_q);
            if (shift_q) rsp_data_q[bit_q] <= jtag_tdo;
            state_q <= ST_HIGH;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        // high phase: the edge that lowers TCK loads the next TMS/TDI
        default: begin
          if (cnt_q == 8'd0) begin
            tck_q <= 1'b0;
            if (k_q == total_q - 7'd1) begin
              tdi_q       <= 1'b0;
              shift_q     <= 1'b0;
              busy_q      <= 1'b0;
              rsp_valid_q <= 1'b1;
              state_q     <= ST_IDLE;
            end else begin
              k_q     <= k_nxt;
              tms_q   <= tms_d;
              tdi_q   <= tdi_d;
              shift_q <= shift_d;
              bit_q   <= bit_d;
              cnt_q   <= DIV_M1;
              state_q <= ST_LOW;
            end
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
      endcase
    end
  end

  assign jtag_tck     = tck_q;
  assign jtag_tms     = tms_q;
  assign jtag_tdi     = tdi_q;
  assign busy         = busy_q;
  assign tap_state    = tap_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_jtag_scan_sequencer.sv
module tb_jtag_scan_sequencer;
  localparam int CLK_DIV = 2;

  localparam logic [3:0] S_TLR = 4'h0, S_RTI = 4'h1, S_SEL_DR = 4'h2, S_CAP_DR = 4'h3,
                         S_SH_DR = 4'h4, S_EX1_DR = 4'h5, S_PA_DR = 4'h6, S_EX2_DR = 4'h7,
                         S_UPD_DR = 4'h8, S_SEL_IR = 4'h9, S_CAP_IR = 4'hA, S_SH_IR = 4'hB,
                         S_EX1_IR = 4'hC, S_PA_IR = 4'hD, S_EX2_IR = 4'hE, S_UPD_IR = 4'hF;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       jtag_tck, jtag_tms, jtag_tdi, jtag_tdo, busy;
  logic [3:0] tap_state;

  jtag_scan_sequencer_if ifc();

  jtag_scan_sequencer #(.CLK_DIV(CLK_DIV)) dut (
    .clk(clk), .rst(rst), .bus(ifc),
    .jtag_tck(jtag_tck), .jtag_tms(jtag_tms), .jtag_tdi(jtag_tdi), .jtag_tdo(jtag_tdo),
    .busy(busy), .tap_state(tap_state)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Target TAP model: 4-bit IR capturing 0001, 8-bit loopback DR preloaded 0x3C.
  function automatic logic [3:0] m_next(input logic [3:0] s, input logic tms);
    case (s)
      S_TLR:    return tms ? S_TLR    : S_RTI;
      S_RTI:    return tms ? S_SEL_DR : S_RTI;
      S_SEL_DR: return tms ? S_SEL_IR : S_CAP_DR;
      S_CAP_DR: return tms ? S_EX1_DR : S_SH_DR;
      S_SH_DR:  return tms ? S_EX1_DR : S_SH_DR;
      S_EX1_DR: return tms ? S_UPD_DR : S_PA_DR;
      S_PA_DR:  return tms ? S_EX2_DR : S_PA_DR;
      S_EX2_DR: return tms ? S_UPD_DR : S_SH_DR;
      S_UPD_DR: return tms ? S_SEL_DR : S_RTI;
      S_SEL_IR: return tms ? S_TLR    : S_CAP_IR;
      S_CAP_IR: return tms ? S_EX1_IR : S_SH_IR;
      S_SH_IR:  return tms ? S_EX1_IR : S_SH_IR;
      S_EX1_IR: return tms ? S_UPD_IR : S_PA_IR;
      S_PA_IR:  return tms ? S_EX2_IR : S_PA_IR;
      S_EX2_IR: return tms ? S_UPD_IR : S_SH_IR;
      default:  return tms ? S_SEL_DR : S_RTI;
    endcase
  endfunction

  logic [3:0] m_state = S_TLR;
  logic [7:0] dr_sr   = 8'h3C;
  logic [3:0] ir_sr   = 4'h0;
  logic       tck_prev = 1'b0;
  logic       run_valid = 1'b0;
  int         run = 0;
  int         tck_cnt = 0, shift_cnt = 0, track_err = 0, tdi_err = 0, phase_err = 0;
  bit         seen_shir = 1'b0, seen_updir = 1'b0;
  logic       tms_log [256];
  logic       tdi_log [256];

  assign jtag_tdo = (m_state == S_SH_DR) ? dr_sr[0] :
                    (m_state == S_SH_IR) ? ir_sr[0] : 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      m_state    = S_TLR;
      tck_prev   = 1'b0;
      run_valid  = 1'b0;
      run        = 0;
      seen_shir  = 1'b0;
      seen_updir = 1'b0;
    end else begin
      if (jtag_tck != tck_prev) begin
        if (run_valid && run != CLK_DIV) phase_err++;
        run_valid = 1'b1;
        run = 1;
      end else begin
        run++;
      end
      if (!busy) run_valid = 1'b0;
      if (jtag_tck && !tck_prev) begin
        if (tck_cnt < 256) tms_log[tck_cnt] = jtag_tms;
        case (m_state)
          S_SH_DR: begin
            dr_sr = {jtag_tdi, dr_sr[7:1]};
            if (shift_cnt < 256) tdi_log[shift_cnt] = jtag_tdi;
            shift_cnt++;
          end
          S_SH_IR: begin
            ir_sr = {jtag_tdi, ir_sr[3:1]};
            if (shift_cnt < 256) tdi_log[shift_cnt] = jtag_tdi;
            shift_cnt++;
          end
          S_CAP_IR: begin
            ir_sr = 4'b0001;
            if (jtag_tdi) tdi_err++;
          end
          default: if (jtag_tdi) tdi_err++;
        endcase
        m_state = m_next(m_state, jtag_tms);
        if (m_state == S_SH_IR)  seen_shir  = 1'b1;
        if (m_state == S_UPD_IR) seen_updir = 1'b1;
        if (m_state !== tap_state) track_err++;
        tck_cnt++;
      end
      tck_prev = jtag_tck;
    end
  end

  function automatic logic [63:0] pack_tms(input int s, input int n);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < n && i < 64; i++) v[i] = tms_log[(s + i) % 256];
    return v;
  endfunction

  function automatic logic [63:0] pack_tdi(input int s, input int n);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < n && i < 64; i++) v[i] = tdi_log[(s + i) % 256];
    return v;
  endfunction

  task automatic run_cmd(input string tag, input logic [1:0] op, input logic [5:0] len,
                         input logic [31:0] data, input int hold,
                         output logic [31:0] rsp, output int lat, output int ntck);
    int t0, waitc, unstable;
    t0 = tck_cnt;
    waitc = 0;
    while (!ifc.cmd_ready && waitc < 100) begin
      @(posedge clk); #1;
      waitc++;
    end
    ifc.cmd_op    = op;
    ifc.cmd_len   = len;
    ifc.cmd_data  = data;
    ifc.cmd_valid = 1'b1;
    @(posedge clk); #1;
    ifc.cmd_valid = 1'b0;
    check({tag, ":busy_after_accept"}, 64'(busy), 64'd1);
    lat = 0;
    while (!ifc.rsp_valid && lat < 5000) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, ":rsp_valid"}, 64'(ifc.rsp_valid), 64'd1);
    check({tag, ":busy_at_rsp"}, 64'(busy), 64'd0);
    check({tag, ":tck_low_at_rsp"}, 64'(jtag_tck), 64'd0);
    rsp = ifc.rsp_data;
    unstable = 0;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (!ifc.rsp_valid || ifc.rsp_data !== rsp || ifc.cmd_ready) unstable++;
    end
    if (hold > 0) check({tag, ":hold_stable"}, 64'(unstable), 64'd0);
    ifc.rsp_ready = 1'b1;
    @(posedge clk); #1;
    ifc.rsp_ready = 1'b0;
    check({tag, ":rsp_cleared"}, 64'(ifc.rsp_valid), 64'd0);
    ntck = tck_cnt - t0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rsp;
    int lat, ntck, s, sc, trk, ph, td, waitc, rsp_seen;

    ifc.cmd_valid = 1'b0;
    ifc.cmd_op    = 2'd0;
    ifc.cmd_len   = 6'd0;
    ifc.cmd_data  = 32'd0;
    ifc.rsp_ready = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst:tck", 64'(jtag_tck), 64'd0);
    check("rst:tms", 64'(jtag_tms), 64'd1);
    check("rst:tdi", 64'(jtag_tdi), 64'd0);
    check("rst:rsp_valid", 64'(ifc.rsp_valid), 64'd0);
    check("rst:rsp_data", 64'(ifc.rsp_data), 64'd0);
    check("rst:busy", 64'(busy), 64'd0);
    check("rst:cmd_ready", 64'(ifc.cmd_ready), 64'd0);
    check("rst:tap_state", 64'(tap_state), 64'h0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("rst:cmd_ready_after", 64'(ifc.cmd_ready), 64'd1);

    // RESET command
    s = tck_cnt;
    run_cmd("reset", 2'd0, 6'd0, 32'd0, 0, rsp, lat, ntck);
    check("reset:tcks", 64'(ntck), 64'd6);
    check("reset:tms_seq", pack_tms(s, 6), 64'h1F);
    check("reset:tap_state", 64'(tap_state), 64'h1);
    check("reset:rsp_data", 64'(rsp), 64'd0);
    check("reset:model_state", 64'(m_state), 64'(S_RTI));

    // IR_SCAN right after reset: one TLR->RTI TCK is prepended
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("ir:tap_tlr", 64'(tap_state), 64'h0);
    s = tck_cnt; trk = track_err;
    run_cmd("ir", 2'd1, 6'd4, 32'hE, 0, rsp, lat, ntck);
    check("ir:tcks", 64'(ntck), 64'd11);
    check("ir:tms_seq", pack_tms(s, 11), 64'h306);
    check("ir:rsp_data", 64'(rsp), 64'h1);
    check("ir:seen_shift_ir", 64'(seen_shir), 64'd1);
    check("ir:seen_update_ir", 64'(seen_updir), 64'd1);
    check("ir:model_rti", 64'(m_state), 64'(S_RTI));
    check("ir:track_err", 64'(track_err - trk), 64'd0);
    check("ir:ir_loaded", 64'(ir_sr), 64'hE);

    // DR_SCAN 8 bits through the loopback DR
    s = tck_cnt; sc = shift_cnt; ph = phase_err; td = tdi_err; trk = track_err;
    run_cmd("dr8", 2'd2, 6'd8, 32'hA5, 0, rsp, lat, ntck);
    check("dr8:tcks", 64'(ntck), 64'd13);
    check("dr8:tms_seq", pack_tms(s, 13), 64'hC01);
    check("dr8:tdi_seq", pack_tdi(sc, 8), 64'hA5);
    check("dr8:rsp_data", 64'(rsp), 64'h3C);
    check("dr8:phase_err", 64'(phase_err - ph), 64'd0);
    check("dr8:tdi_outside_shift", 64'(tdi_err - td), 64'd0);
    check("dr8:track_err", 64'(track_err - trk), 64'd0);

    // DR_SCAN 32 bits with the response held off for 10 clks
    sc = shift_cnt; ph = phase_err;
    run_cmd("dr32", 2'd2, 6'd32, 32'hFFFF_FFFF, 10, rsp, lat, ntck);
    check("dr32:tcks", 64'(ntck), 64'd37);
    check("dr32:tdi_seq", pack_tdi(sc, 32), 64'hFFFF_FFFF);
    check("dr32:rsp_data", 64'(rsp), 64'hFFFF_FFA5);
    check("dr32:phase_err", 64'(phase_err - ph), 64'd0);
    check("dr32:tap_rti", 64'(tap_state), 64'h1);

    // degenerate lengths
    run_cmd("dr0", 2'd2, 6'd0, 32'h1234, 0, rsp, lat, ntck);
    check("dr0:latency", 64'(lat), 64'd1);
    check("dr0:tcks", 64'(ntck), 64'd0);
    check("dr0:rsp_data", 64'(rsp), 64'd0);
    run_cmd("ir40", 2'd1, 6'd40, 32'hFFFF_FFFF, 0, rsp, lat, ntck);
    check("ir40:latency", 64'(lat), 64'd1);
    check("ir40:tcks", 64'(ntck), 64'd0);
    check("ir40:rsp_data", 64'(rsp), 64'd0);

    // IDLE 5
    s = tck_cnt; td = tdi_err;
    run_cmd("idle5", 2'd3, 6'd5, 32'hFFFF_FFFF, 0, rsp, lat, ntck);
    check("idle5:tcks", 64'(ntck), 64'd5);
    check("idle5:tms_seq", pack_tms(s, 5), 64'd0);
    check("idle5:tdi", 64'(tdi_err - td), 64'd0);
    check("idle5:rsp_data", 64'(rsp), 64'd0);
    check("idle5:tap_rti", 64'(tap_state), 64'h1);

    // reset during shift bit 10 of a 32-bit DR scan
    s = tck_cnt;
    ifc.cmd_op    = 2'd2;
    ifc.cmd_len   = 6'd32;
    ifc.cmd_data  = 32'h1234_5678;
    ifc.cmd_valid = 1'b1;
    @(posedge clk); #1;
    ifc.cmd_valid = 1'b0;
    waitc = 0;
    while (!((tck_cnt - s) >= 13 && !jtag_tck) && waitc < 500) begin
      @(posedge clk); #1;
      waitc++;
    end
    check("abort:reached_bit10", 64'(tck_cnt - s), 64'd13);
    check("abort:tdi_bit10", 64'(jtag_tdi), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort:tck", 64'(jtag_tck), 64'd0);
    check("abort:rsp_valid", 64'(ifc.rsp_valid), 64'd0);
    check("abort:busy", 64'(busy), 64'd0);
    check("abort:tap_state", 64'(tap_state), 64'h0);
    rst = 1'b0;
    s = tck_cnt;
    rsp_seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (ifc.rsp_valid) rsp_seen++;
    end
    check("abort:no_response", 64'(rsp_seen), 64'd0);
    check("abort:no_tck", 64'(tck_cnt - s), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
